// File: rtl/dl11_pkg.sv
`default_nettype none
// ============================================================================
// Package : dl11_pkg -- register offsets, CSR bit positions, FSM encodings
// Revision: 1.0
// ============================================================================
package dl11_pkg;

    localparam logic [1:0] RCSR_A = 2'd0;
    localparam logic [1:0] RBUF_A = 2'd1;
    localparam logic [1:0] XCSR_A = 2'd2;
    localparam logic [1:0] XBUF_A = 2'd3;

    localparam int DONE_B  = 7;
    localparam int IE_B    = 6;
    localparam int MAINT_B = 2;
    localparam int OVR_B   = 14;
    localparam int ERR_B   = 15;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_BUSY = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ULD  = 2'd1,
        R_CAP  = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/dl11_baud_gen.sv
`default_nettype none
// ============================================================================
// Module  : dl11_baud_gen -- rxclk (16x baud) and txclk (1x baud) from clk
// Revision: 1.0
// ============================================================================
module dl11_baud_gen #(
    parameter int RX_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic rxclk,
    output logic txclk
);

    localparam int             HALF      = RX_DIV / 2;
    localparam int             CW        = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q,   cnt_d;
    logic          rxclk_q, rxclk_d;
    logic [2:0]    rise_q,  rise_d;
    logic          txclk_q, txclk_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        rxclk_d = rxclk_q;
        rise_d  = rise_q;
        txclk_d = txclk_q;
        if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            rxclk_d = ~rxclk_q;
            // rxclk is about to rise: count it, flip txclk every 8th rise
            if (!rxclk_q) begin
                rise_d = rise_q + 3'd1;
                if (rise_q == 3'd7) begin
                    txclk_d = ~txclk_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            rxclk_q <= 1'b0;
            rise_q  <= 3'd0;
            txclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rxclk_q <= rxclk_d;
            rise_q  <= rise_d;
            txclk_q <= txclk_d;
        end
    end

    assign rxclk = rxclk_q;
    assign txclk = txclk_q;

endmodule
`default_nettype wire

// File: rtl/dl11_bus_if.sv
`default_nettype none
// ============================================================================
// Module  : dl11_bus_if -- DL11 console registers, uart handshakes and irqs
// Revision: 1.0   Optional maintenance loopback: define DL11_MAINT_EN
// ============================================================================
module dl11_bus_if #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600,
    parameter int RX_DIV = CLK_HZ / (BAUD * 16)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rx_irq,
    output logic        tx_irq,
    output logic        txclk,
    output logic        rxclk,
    output logic        ld_tx_data,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_empty,
    output logic        uld_rx_data,
    input  logic [7:0]  rx_data,
    output logic        rx_enable,
    input  logic        rx_empty,
    input  logic        ser_tx,
    input  logic        ser_rx_pin,
    output logic        uart_rx_in
);

    import dl11_pkg::*;

    tx_state_e  tx_state_q, tx_state_d;
    rx_state_e  rx_state_q, rx_state_d;

    logic       tx_e_m_q, tx_e_m_d, tx_e_s_q, tx_e_s_d;
    logic       rx_e_m_q, rx_e_m_d, rx_e_s_q, rx_e_s_d;
    logic       rx_done_q, rx_done_d, rx_ie_q, rx_ie_d, rx_ovr_q, rx_ovr_d;
    logic [7:0] rbuf_q, rbuf_d;
    logic       tx_ready_q, tx_ready_d, tx_ie_q, tx_ie_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       rx_irq_q, rx_irq_d, tx_irq_q, tx_irq_d;
    logic       maint_q;

    logic       w_wr_rcsr, w_wr_xcsr, w_wr_xbuf, w_rd_rbuf;
    logic       w_tx_accept, w_rx_cap;
    logic       unused_inputs;

    dl11_baud_gen #(
        .RX_DIV (RX_DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .rxclk  (rxclk),
        .txclk  (txclk)
    );

    assign w_wr_rcsr   = sel & wr & (addr == RCSR_A);
    assign w_wr_xcsr   = sel & wr & (addr == XCSR_A);
    assign w_wr_xbuf   = sel & wr & (addr == XBUF_A);
    assign w_rd_rbuf   = sel & rd & (addr == RBUF_A);
    assign w_tx_accept = w_wr_xbuf & tx_ready_q & (tx_state_q == T_IDLE);

    // ---------------- FSM state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            T_IDLE:  if (w_tx_accept) tx_state_d = T_LOAD;
            T_LOAD:  if (!tx_e_s_q)   tx_state_d = T_BUSY;
            T_BUSY:  if (tx_e_s_q)    tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase

        rx_state_d = rx_state_q;
        case (rx_state_q)
            R_IDLE:  if (!rx_e_s_q)   rx_state_d = R_ULD;
            R_ULD:   if (rx_e_s_q)    rx_state_d = R_CAP;
            R_CAP:   rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        ld_tx_data  = (tx_state_q == T_LOAD);
        uld_rx_data = (rx_state_q == R_ULD);
        w_rx_cap    = (rx_state_q == R_CAP);
    end

    // ---------------- register file next values ----------------
    always_comb begin
        tx_e_m_d   = tx_empty;
        tx_e_s_d   = tx_e_m_q;
        rx_e_m_d   = rx_empty;
        rx_e_s_d   = rx_e_m_q;
        rx_done_d  = rx_done_q;
        rx_ovr_d   = rx_ovr_q;
        rbuf_d     = rbuf_q;
        rx_ie_d    = rx_ie_q;
        tx_ie_d    = tx_ie_q;
        tx_ready_d = tx_ready_q;
        tx_data_d  = tx_data_q;
        rx_irq_d   = rx_done_q & rx_ie_q;
        tx_irq_d   = tx_ready_q & tx_ie_q;

        if (w_wr_rcsr) rx_ie_d = wdata[IE_B];
        if (w_wr_xcsr) tx_ie_d = wdata[IE_B];

        if (w_rd_rbuf) begin
            rx_done_d = 1'b0;
            rx_ovr_d  = 1'b0;
        end
        // A capture coinciding with an RBUF read wins and is not an overrun
        if (w_rx_cap) begin
            rbuf_d    = rx_data;
            rx_ovr_d  = rx_done_q & ~w_rd_rbuf;
            rx_done_d = 1'b1;
        end

        if (w_tx_accept) begin
            tx_data_d  = wdata[7:0];
            tx_ready_d = 1'b0;
        end else if ((tx_state_q == T_BUSY) && tx_e_s_q) begin
            tx_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_e_m_q   <= 1'b1;
            tx_e_s_q   <= 1'b1;
            rx_e_m_q   <= 1'b1;
            rx_e_s_q   <= 1'b1;
            rx_done_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rbuf_q     <= 8'h00;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_data_q  <= 8'h00;
            rx_irq_q   <= 1'b0;
            tx_irq_q   <= 1'b0;
        end else begin
            tx_e_m_q   <= tx_e_m_d;
            tx_e_s_q   <= tx_e_s_d;
            rx_e_m_q   <= rx_e_m_d;
            rx_e_s_q   <= rx_e_s_d;
            rx_done_q  <= rx_done_d;
            rx_ovr_q   <= rx_ovr_d;
            rbuf_q     <= rbuf_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
            tx_ready_q <= tx_ready_d;
            tx_data_q  <= tx_data_d;
            rx_irq_q   <= rx_irq_d;
            tx_irq_q   <= tx_irq_d;
        end
    end

`ifdef DL11_MAINT_EN
    logic maint_d;

    always_comb begin
        maint_d = maint_q;
        if (w_wr_xcsr) maint_d = wdata[MAINT_B];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) maint_q <= 1'b0;
        else       maint_q <= maint_d;
    end

    assign uart_rx_in = maint_q ? ser_tx : ser_rx_pin;
`else
    assign maint_q    = 1'b0;
    assign uart_rx_in = ser_rx_pin;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        rdata = 16'h0000;
        if (!reset && sel) begin
            case (addr)
                RCSR_A: begin
                    rdata[DONE_B] = rx_done_q;
                    rdata[IE_B]   = rx_ie_q;
                end
                RBUF_A: begin
                    rdata[7:0]   = rbuf_q;
                    rdata[OVR_B] = rx_ovr_q;
                    rdata[ERR_B] = rx_ovr_q;
                end
                XCSR_A: begin
                    rdata[DONE_B]  = tx_ready_q;
                    rdata[IE_B]    = tx_ie_q;
                    rdata[MAINT_B] = maint_q;
                end
                default: rdata = 16'h0000;
            endcase
        end
    end

    assign tx_data       = tx_data_q;
    assign rx_irq        = rx_irq_q;
    assign tx_irq        = tx_irq_q;
    assign tx_enable     = ~reset;
    assign rx_enable     = ~reset;
    assign unused_inputs = ^{wdata, ser_tx};

endmodule
`default_nettype wire

// File: tb/tb_dl11_bus_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_dl11_bus_if -- randomized scoreboard bench with a uart model
// Revision: 1.0
// ============================================================================
module tb_dl11_bus_if;

    localparam int CLK_HZ = 1536000;
    localparam int BAUD   = 9600;
    localparam int RX_DIV = 10;
`ifdef DL11_MAINT_EN
    localparam bit HAS_MAINT = 1'b1;
`else
    localparam bit HAS_MAINT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        rx_irq, tx_irq, txclk, rxclk;
    logic        ld_tx_data, tx_enable, uld_rx_data, rx_enable, uart_rx_in;
    logic [7:0]  tx_data;
    logic        tx_empty, ser_tx;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        ser_rx_pin = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    dl11_bus_if #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RX_DIV(RX_DIV)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata), .rx_irq(rx_irq), .tx_irq(tx_irq),
        .txclk(txclk), .rxclk(rxclk), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
        .tx_enable(tx_enable), .tx_empty(tx_empty), .uld_rx_data(uld_rx_data),
        .rx_data(rx_data), .rx_enable(rx_enable), .rx_empty(rx_empty),
        .ser_tx(ser_tx), .ser_rx_pin(ser_rx_pin), .uart_rx_in(uart_rx_in)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model of the register set ----------------
    bit         m_done, m_rie, m_ovr, m_ready, m_tie, m_maint;
    logic [7:0] m_rbuf;
    logic [15:0] rd_q[$];
    logic [7:0]  tx_q[$];

    task automatic model_reset();
        m_done = 0; m_rie = 0; m_ovr = 0; m_rbuf = 8'h00;
        m_ready = 1; m_tie = 0; m_maint = 0;
    endtask

    function automatic logic [15:0] exp_reg(input logic [1:0] a);
        logic [15:0] v;
        case (a)
            2'd0:    v = {8'h00, m_done, m_rie, 6'h00};
            2'd1:    v = {m_ovr, m_ovr, 6'h00, m_rbuf};
            2'd2:    v = {8'h00, m_ready, m_tie, 3'b000, m_maint, 2'b00};
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        sel = 1; wr = 1; addr = a; wdata = d;
        tick();
        sel = 0; wr = 0;
        case (a)
            2'd0: m_rie = d[6];
            2'd2: begin m_tie = d[6]; m_maint = HAS_MAINT & d[2]; end
            2'd3: if (m_ready) begin tx_q.push_back(d[7:0]); m_ready = 0; end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [1:0] a);
        rd_q.push_back(exp_reg(a));
        sel = 1; rd = 1; addr = a;
        tick();
        sel = 0; rd = 0;
        if (a == 2'd1) begin m_done = 0; m_ovr = 0; end
    endtask

    task automatic check_irq();
        check("rx_irq", {15'h0, rx_irq}, {15'h0, m_done & m_rie});
        check("tx_irq", {15'h0, tx_irq}, {15'h0, m_ready & m_tie});
    endtask

    task automatic check_rx_in();
        check("uart_rx_in", {15'h0, uart_rx_in}, {15'h0, (m_maint ? ser_tx : ser_rx_pin)});
    endtask

    // ---------------- monitors ----------------
    logic [15:0] mon_rd;
    always @(negedge clk) begin
        if (sel && rd) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rdata: got 0x%04h expected none queued", rdata);
            end else begin
                mon_rd = rd_q.pop_front();
                check("rdata", rdata, mon_rd);
            end
        end
    end

    logic       ld_seen = 1'b0;
    logic [7:0] mon_tx;
    always @(negedge clk) begin
        if (reset || !ld_tx_data) begin
            ld_seen <= 1'b0;
        end else if (tx_empty && !ld_seen) begin
            ld_seen <= 1'b1;
            if (tx_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL tx_data: got 0x%02h expected no load", tx_data);
            end else begin
                mon_tx = tx_q.pop_front();
                check("tx_data", {8'h00, tx_data}, {8'h00, mon_tx});
            end
        end
    end

    // ---------------- uart transmitter model ----------------
    logic [7:0] u_tx_sh;
    int         u_tx_bits;
    logic       txclk_d1;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_empty  <= 1'b1;
            ser_tx    <= 1'b1;
            u_tx_bits <= 0;
            txclk_d1  <= 1'b0;
            u_tx_sh   <= 8'h00;
        end else begin
            txclk_d1 <= txclk;
            if (ld_tx_data && tx_empty && u_tx_bits == 0) begin
                u_tx_sh   <= tx_data;
                tx_empty  <= 1'b0;
                u_tx_bits <= 11;
            end else if (u_tx_bits > 0 && txclk && !txclk_d1) begin
                if (u_tx_bits == 11) ser_tx <= 1'b0;
                else if (u_tx_bits >= 3) begin
                    ser_tx  <= u_tx_sh[0];
                    u_tx_sh <= u_tx_sh >> 1;
                end else if (u_tx_bits == 2) ser_tx <= 1'b1;
                else tx_empty <= 1'b1;
                u_tx_bits <= u_tx_bits - 1;
            end
        end
    end

    // ---------------- helper sequences ----------------
    task automatic rx_inject(input logic [7:0] b, input bit collide);
        int n = 0;
        rx_data = b; rx_empty = 0;
        while (!uld_rx_data && n < 50) begin tick(); n++; end
        if (!uld_rx_data) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_uld: got 0 expected 1 within 50 clk");
            rx_empty = 1;
            return;
        end
        tick();
        rx_empty = 1;
        n = 0;
        while (uld_rx_data && n < 20) begin tick(); n++; end
        check("uld_drop", {15'h0, uld_rx_data}, 16'h0000);
        if (collide) bus_read(2'd1);
        else repeat (2) tick();
        m_ovr  = m_done;
        m_rbuf = b;
        m_done = 1;
        tick();
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (tx_empty && n < 50) begin tick(); n++; end
        check("tx_busy", {15'h0, tx_empty}, 16'h0000);
        n = 0;
        while (!tx_empty && n < 4000) begin tick(); n++; end
        check("tx_done", {15'h0, tx_empty}, 16'h0001);
        repeat (6) tick();
        m_ready = 1;
    endtask

    task automatic decode_frame(input logic [7:0] exp);
        int n = 0;
        logic [7:0] got;
        got = 8'h00;
        while (ser_tx && n < 400) begin tick(); n++; end
        check("start_edge", {15'h0, ser_tx}, 16'h0000);
        repeat (80) tick();
        check("start_bit", {15'h0, ser_tx}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            repeat (160) tick();
            got[i] = ser_tx;
        end
        repeat (160) tick();
        check("stop_bit", {15'h0, ser_tx}, 16'h0001);
        check("ser_byte", {8'h00, got}, {8'h00, exp});
    endtask

    task automatic measure(input bit use_tx, output int cyc);
        bit prev, cur;
        int t0 = 0;
        int rises = 0;
        cyc = -1;
        prev = use_tx ? txclk : rxclk;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cur = use_tx ? txclk : rxclk;
            if (cur && !prev) begin
                if (rises == 0) t0 = i;
                else begin cyc = i - t0; break; end
                rises++;
            end
            prev = cur;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int per;
        int n;
        model_reset();

        // reset values
        repeat (3) tick();
        sel = 1; addr = 2'd2;
        #1;
        check("rst_rdata", rdata, 16'h0000);
        sel = 0;
        check("rst_tx_en", {15'h0, tx_enable}, 16'h0000);
        check("rst_rx_en", {15'h0, rx_enable}, 16'h0000);
        check("rst_clks", {14'h0, txclk, rxclk}, 16'h0000);
        check("rst_strobes", {14'h0, ld_tx_data, uld_rx_data}, 16'h0000);
        check("rst_tx_data", {8'h00, tx_data}, 16'h0000);
        check("rst_irqs", {14'h0, rx_irq, tx_irq}, 16'h0000);
        reset = 0;
        tick();
        check("tx_en", {15'h0, tx_enable}, 16'h0001);
        check("rx_en", {15'h0, rx_enable}, 16'h0001);
        bus_read(2'd2);
        bus_read(2'd0);
        bus_read(2'd1);
        check_irq();
        check_rx_in();

        measure(1'b0, per);
        check("rxclk_period", per[15:0], 16'd10);
        measure(1'b1, per);
        check("txclk_period", per[15:0], 16'd160);

        // transmit with irq enabled, second write while busy is dropped
        bus_write(2'd2, 16'h0040);
        bus_write(2'd3, 16'h0041);
        bus_read(2'd2);
        bus_write(2'd3, 16'h0055);
        decode_frame(8'h41);
        wait_tx_done();
        bus_read(2'd2);
        tick();
        check_irq();

        // receive, read clears done
        rx_inject(8'hA5, 1'b0);
        bus_read(2'd0);
        bus_read(2'd1);
        bus_read(2'd0);

        // overrun
        bus_write(2'd0, 16'h0040);
        rx_inject(8'h12, 1'b0);
        repeat (2) tick();
        check_irq();
        rx_inject(8'h34, 1'b0);
        bus_read(2'd1);
        bus_read(2'd1);
        repeat (2) tick();
        check_irq();

        // capture and RBUF read in the same clock
        rx_inject(8'h77, 1'b0);
        rx_inject(8'h88, 1'b1);
        bus_read(2'd0);
        bus_read(2'd1);

        // maintenance bit / line routing
        bus_write(2'd2, 16'h0044);
        bus_read(2'd2);
        ser_rx_pin = 0; tick(); check_rx_in();
        ser_rx_pin = 1; tick(); check_rx_in();
        bus_write(2'd2, 16'h0000);
        ser_rx_pin = 0; tick(); check_rx_in();
        ser_rx_pin = 1;

        // reset while transmitting
        bus_write(2'd2, 16'h0040);
        bus_write(2'd3, 16'h003C);
        n = 0;
        while (tx_empty && n < 50) begin tick(); n++; end
        repeat (300) tick();
        reset = 1;
        #1;
        check("rstmid_ld", {15'h0, ld_tx_data}, 16'h0000);
        check("rstmid_ser", {15'h0, ser_tx}, 16'h0001);
        check("rstmid_irq", {15'h0, tx_irq}, 16'h0000);
        repeat (2) tick();
        reset = 0;
        model_reset();
        tx_q.delete();
        tick();
        bus_read(2'd2);
        bus_write(2'd3, 16'h00C3);
        decode_frame(8'hC3);
        wait_tx_done();

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0: bus_write(2'($urandom_range(0, 2)), 16'($urandom));
                1: bus_read(2'($urandom_range(0, 3)));
                2: rx_inject(8'($urandom), 1'($urandom_range(0, 1)));
                3: begin
                    bus_write(2'd3, 16'($urandom));
                    bus_read(2'd2);
                    bus_write(2'd3, 16'($urandom));
                    wait_tx_done();
                end
                default: begin
                    ser_rx_pin = 1'($urandom);
                    tick();
                    check_rx_in();
                end
            endcase
            repeat (3) tick();
            check_irq();
        end

        repeat (4) tick();
        check("rd_q_left", 16'(rd_q.size()), 16'h0000);
        check("tx_q_left", 16'(tx_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dl11_bus_if.md
Name: dl11_bus_if

Overview:
- Bus-side register front end for the serial uart: presents a DL11-style console register set (RCSR, RBUF, XCSR, XBUF) to the CPU I/O page.
- Generates the uart's txclk/rxclk from the single system clock.
- Runs the ld_tx_data / uld_rx_data handshakes against the uart's tx_empty / rx_empty flags.
- Produces receive and transmit interrupt requests.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BAUD, 9600, line rate; rxclk = 16x BAUD, txclk = 1x BAUD.
- RX_DIV, CLK_HZ/(BAUD*16), clk cycles per rxclk period; must be even and >= 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  I/O page select for this device.
- addr  in  2  word offset: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF.
- rd  in  1  read strobe, one clk.
- wr  in  1  write strobe, one clk, word write.
- wdata  in  16  write data.
- rdata  out  16  read data, combinational from addr when sel.
- rx_irq  out  1  receive interrupt request, level.
- tx_irq  out  1  transmit interrupt request, level.
- txclk  out  1  uart transmit clock.
- rxclk  out  1  uart receive clock.
- ld_tx_data  out  1  uart load strobe.
- tx_data  out  8  uart transmit byte.
- tx_enable  out  1  uart transmit enable; tied 1 after reset.
- tx_empty  in  1  uart transmitter empty.
- uld_rx_data  out  1  uart unload strobe.
- rx_data  in  8  uart received byte.
- rx_enable  out  1  uart receive enable; tied 1 after reset.
- rx_empty  in  1  uart receiver empty.
- ser_tx  in  1  uart tx_out, monitored for loopback.
- ser_rx_pin  in  1  external RS-232 receive line.
- uart_rx_in  out  1  drives uart rx_in.

Behaviour:
- Reset values:
  - rdata 0, rx_irq 0, tx_irq 0, txclk 0, rxclk 0.
  - ld_tx_data 0, tx_data 0, uld_rx_data 0.
  - tx_enable 0 and rx_enable 0 during reset, 1 otherwise.
  - RCSR.done 0, RCSR.ie 0, RBUF 0, XCSR.ready 1, XCSR.ie 0.
- Clocks:
  - rxclk toggles every RX_DIV/2 clk.
  - txclk toggles on every 8th rxclk rising edge, giving a 16:1 division.
  - Both clocks are registered with 50% duty.
- Synchronisers: tx_empty and rx_empty pass through 2-flop synchronisers on clk (tx_e_s, rx_e_s) before any use.
- Register map:
  - RCSR: bit7 done (RO), bit6 ie (RW); other bits read 0.
  - RBUF (RO): [7:0] data, [14] overrun, [15] error = overrun.
  - XCSR: bit7 ready (RO), bit6 ie (RW), bit2 maint (see Optional Feature).
  - XBUF: write [7:0] only; reads 0.
- Reading RBUF (sel&rd&addr==1) clears RCSR.done and RBUF[15:14] at the next clk edge; rdata still shows the pre-clear values in that cycle.
- TX FSM, states T_IDLE, T_LOAD, T_BUSY:
  - T_IDLE: write to XBUF with ready=1 latches tx_data, clears ready, goes to T_LOAD.
  - A write to XBUF with ready=0 is ignored entirely.
  - T_LOAD: hold ld_tx_data=1 until tx_e_s==0, then drop it and go to T_BUSY.
  - T_BUSY: on tx_e_s==1, set ready and go to T_IDLE.
- RX FSM, states R_IDLE, R_ULD, R_CAP:
  - R_IDLE: on rx_e_s==0, go to R_ULD.
  - R_ULD: hold uld_rx_data=1 until rx_e_s==1, then go to R_CAP.
  - R_CAP: one clk; RBUF[7:0] <= rx_data.
  - R_CAP when done already 1: set overrun and error, old byte lost.
  - R_CAP when done is 0: clear overrun and error.
  - R_CAP sets done and returns to R_IDLE.
- Simultaneous RBUF read and R_CAP in the same clk: capture wins, so done=1 afterwards and overrun is not set.
- Interrupts: rx_irq = done & RCSR.ie; tx_irq = ready & XCSR.ie, registered, one clk latency. Setting ie while done/ready is already 1 raises the irq on the next clk.
- Reset mid-character: both FSMs return to idle immediately. The partial uart frame is abandoned because the uart shares the reset.

Optional Feature:
- Macro: DL11_MAINT_EN.
- With the macro defined:
  - XCSR bit2 maint is RW.
  - When maint=1: uart_rx_in = ser_tx and ser_rx_pin is ignored (internal loopback).
  - When maint=0: uart_rx_in = ser_rx_pin.
- Without the macro: bit2 reads 0, writes to it are ignored, and uart_rx_in = ser_rx_pin.

Decomposition:
- Shared package dl11_pkg holds:
  - register offsets (RCSR_A=0, RBUF_A=1, XCSR_A=2, XBUF_A=3);
  - CSR bit positions (DONE_B=7, IE_B=6, MAINT_B=2, OVR_B=14, ERR_B=15);
  - TX/RX state encodings.
- One sub-module, dl11_baud_gen: RX_DIV counter plus the 16:1 divider producing rxclk and txclk.

Test Plan:
- Bench wiring: CLK_HZ=1536000, BAUD=9600 (RX_DIV=10), with the real uart attached. Loopback scenarios use DL11_MAINT_EN.
- Reset -> XCSR reads 0x0080, RCSR reads 0x0000, tx_irq=0, rxclk period 10 clk, txclk period 160 clk.
- Write XCSR=0x0040, then XBUF=0x0041 -> ready drops, ser_tx emits start, 0x41 LSB-first, stop at 160 clk/bit; ready returns to 1 and tx_irq=1.
- Second XBUF write of 0x55 while ready=0 -> ignored; only 0x41 is transmitted.
- Maint=1, write XBUF=0xA5 -> RCSR.done=1, RBUF=0x00A5. Reading RBUF clears done; a re-read of RCSR gives 0x0000.
- Two looped bytes 0x12 then 0x34 with no RBUF read -> RBUF=0xC034 (error+overrun); the following RBUF read clears bits 15:14.
- Assert reset during T_BUSY -> ready=1, ld_tx_data=0, ser_tx=1 immediately; a new XBUF write after reset transmits normally.
